pacman_frame_ctrl: RTL and testbench

- Frame-rate initiator for the pacman sprite animator's go/done handshake. It sits between the top-level game logic and the animator/eraser datapaths.
- Once per frame tick it first requests an erase of the last-drawn sprite box, then requests an animate/draw step. It captures the animator's returned position, applies screen-bound checks and holds the authoritative pacman position.

---
 rtl/pacman_frame_ctrl_pkg.sv | 45 ++++
 rtl/pacman_frame_ctrl_if.sv | 37 +++
 rtl/pacman_frame_ctrl_frame_tick_gen.sv | 45 ++++
 rtl/pacman_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pacman_frame_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pacman_frame_ctrl_pkg
// Shared definitions for the pacman frame controller:
//   - coordinate widths (X_W, Y_W)
//   - screen and sprite geometry, plus the legal sprite start limits
//   - default frame / watchdog timing
//   - the controller state encoding
//   - an inclusive range-check helper
// -----------------------------------------------------------------------------
package pacman_frame_ctrl_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 20;
  localparam int SPRITE_H = 20;

  // Highest start coordinate that keeps the whole sprite on screen.
  localparam int SPRITE_X_MAX = SCREEN_W - SPRITE_W;
  localparam int SPRITE_Y_MAX = SCREEN_H - SPRITE_H;

  localparam int FRAME_CYCLES_DEF = 833333;  // 50 MHz / 60 Hz
  localparam int TIMEOUT_DEF      = 4096;
  localparam int INIT_X_DEF       = 70;
  localparam int INIT_Y_DEF       = 50;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_TICK  = 3'd1,
    ST_ERASE_REQ  = 3'd2,
    ST_ERASE_WAIT = 3'd3,
    ST_ANIM_REQ   = 3'd4,
    ST_ANIM_WAIT  = 3'd5,
    ST_UPDATE     = 3'd6
  } state_t;

  // Inclusive range check. Callers zero-extend the coordinate into an int,
  // so the comparison behaves as unsigned on the original coordinate.
  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pacman_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// pacman_frame_ctrl_if
// Go/done handshake bundle between the frame controller and the
// eraser/animator datapaths.
//   master (controller): drives erase_go/erase_x/erase_y and
//                        anim_go/anim_in_x/anim_in_y; receives erase_done,
//                        anim_done and anim_out_x/anim_out_y.
//   slave  (datapaths) : the mirror image.
// -----------------------------------------------------------------------------
interface pacman_frame_ctrl_if;
  import pacman_frame_ctrl_pkg::*;

  logic           erase_go;
  logic           erase_done;
  logic [X_W-1:0] erase_x;
  logic [Y_W-1:0] erase_y;

  logic           anim_go;
  logic           anim_done;
  logic [X_W-1:0] anim_in_x;
  logic [Y_W-1:0] anim_in_y;
  logic [X_W-1:0] anim_out_x;
  logic [Y_W-1:0] anim_out_y;

  modport master (
    output erase_go, erase_x, erase_y,
    output anim_go, anim_in_x, anim_in_y,
    input  erase_done, anim_done, anim_out_x, anim_out_y
  );

  modport slave (
    input  erase_go, erase_x, erase_y,
    input  anim_go, anim_in_x, anim_in_y,
    output erase_done, anim_done, anim_out_x, anim_out_y
  );

endinterface

// File: rtl/pacman_frame_ctrl_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Loadable down-counter with a zero flag. It is used both as the frame
// tick counter and as the handshake watchdog.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   load          : load LOAD_VAL (has priority over dec)
//   dec           : decrement by one; the count holds at zero
//   zero          : count is zero
// -----------------------------------------------------------------------------
module frame_tick_gen #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] LOAD_VAL  = '1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = LOAD_VAL;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg <= RESET_VAL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pacman_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pacman_frame_ctrl
// Frame-rate initiator for the pacman sprite animator. Once per frame tick it
// asks the eraser to clear the last-drawn box, then asks the animator for a
// new position, bounds-checks the result and holds the committed position.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   enable        : game running (level)
//   hs            : go/done handshake to eraser and animator (master side)
//   pos_x, pos_y  : committed sprite position
//   busy          : a frame handshake is in progress
//   hit_wall      : one-cycle pulse when the animator's position is rejected
//   timeout_err   : sticky flag, set when a done never arrived
// -----------------------------------------------------------------------------
module pacman_frame_ctrl
  import pacman_frame_ctrl_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int INIT_X       = INIT_X_DEF,
  parameter int INIT_Y       = INIT_Y_DEF,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = SPRITE_X_MAX,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = SPRITE_Y_MAX,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  pacman_frame_ctrl_if.master hs,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y,
  output logic                busy,
  output logic                hit_wall,
  output logic                timeout_err
);

  localparam int             CNT_W      = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam int             WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LOAD    = WD_W'(TIMEOUT - 1);
  localparam logic [X_W-1:0]   INIT_X_V   = X_W'(INIT_X);
  localparam logic [Y_W-1:0]   INIT_Y_V   = Y_W'(INIT_Y);

  state_t state_reg;
  state_t state_next;

  logic [X_W-1:0] pos_x_reg;
  logic [Y_W-1:0] pos_y_reg;
  logic [X_W-1:0] drawn_x_reg;
  logic [Y_W-1:0] drawn_y_reg;
  logic [X_W-1:0] cand_x_reg;
  logic [Y_W-1:0] cand_y_reg;
  logic           timeout_err_reg;

  logic frame_load;
  logic frame_dec;
  logic frame_zero;
  logic wd_load;
  logic wd_dec;
  logic wd_zero;
  logic capture;
  logic commit;
  logic abort;
  logic cand_ok;

  // Frame tick: reloaded on every entry to WAIT_TICK, counted down there.
  frame_tick_gen #(
    .WIDTH     (CNT_W),
    .LOAD_VAL  (FRAME_LOAD),
    .RESET_VAL (FRAME_LOAD)
  ) u_frame_cnt (
    .clock  (clock),
    .resetn (resetn),
    .load   (frame_load),
    .dec    (frame_dec),
    .zero   (frame_zero)
  );

  // Watchdog: reloaded in each REQ state so it restarts on every wait entry;
  // reaching zero inside a wait state means TIMEOUT wait cycles have elapsed.
  frame_tick_gen #(
    .WIDTH     (WD_W),
    .LOAD_VAL  (WD_LOAD),
    .RESET_VAL ('0)
  ) u_watchdog (
    .clock  (clock),
    .resetn (resetn),
    .load   (wd_load),
    .dec    (wd_dec),
    .zero   (wd_zero)
  );

  assign cand_ok = in_range(int'(cand_x_reg), X_MIN, X_MAX) &&
                   in_range(int'(cand_y_reg), Y_MIN, Y_MAX);

  always_comb begin
    state_next = state_reg;
    frame_load = 1'b0;
    frame_dec  = 1'b0;
    wd_load    = 1'b0;
    wd_dec     = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          frame_load = 1'b1;
          state_next = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        frame_dec = 1'b1;
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (frame_zero) begin
          state_next = ST_ERASE_REQ;
        end
      end
      ST_ERASE_REQ: begin
        wd_load    = 1'b1;
        state_next = ST_ERASE_WAIT;
      end
      ST_ERASE_WAIT: begin
        wd_dec = 1'b1;
        // anim_done is deliberately not looked at here.
        if (hs.erase_done) begin
          state_next = ST_ANIM_REQ;
        end else if (wd_zero) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ANIM_REQ: begin
        wd_load    = 1'b1;
        state_next = ST_ANIM_WAIT;
      end
      ST_ANIM_WAIT: begin
        wd_dec = 1'b1;
        if (hs.anim_done) begin
          capture    = 1'b1;
          state_next = ST_UPDATE;
        end else if (wd_zero) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        commit     = cand_ok;
        frame_load = 1'b1;
        state_next = ST_WAIT_TICK;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      pos_x_reg       <= INIT_X_V;
      pos_y_reg       <= INIT_Y_V;
      drawn_x_reg     <= INIT_X_V;
      drawn_y_reg     <= INIT_Y_V;
      cand_x_reg      <= INIT_X_V;
      cand_y_reg      <= INIT_Y_V;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // drawn takes the animator's output even when it is later rejected,
      // because that is what the animator actually put on screen.
      if (capture) begin
        drawn_x_reg <= hs.anim_out_x;
        drawn_y_reg <= hs.anim_out_y;
        cand_x_reg  <= hs.anim_out_x;
        cand_y_reg  <= hs.anim_out_y;
      end
      if (commit) begin
        pos_x_reg <= cand_x_reg;
        pos_y_reg <= cand_y_reg;
      end
      if (abort) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  assign hs.erase_go  = (state_reg == ST_ERASE_REQ);
  assign hs.anim_go   = (state_reg == ST_ANIM_REQ);
  assign hs.erase_x   = drawn_x_reg;
  assign hs.erase_y   = drawn_y_reg;
  assign hs.anim_in_x = pos_x_reg;
  assign hs.anim_in_y = pos_y_reg;

  assign pos_x       = pos_x_reg;
  assign pos_y       = pos_y_reg;
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_WAIT_TICK);
  assign hit_wall    = (state_reg == ST_UPDATE) && !cand_ok;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_pacman_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pacman_frame_ctrl
// Drives the frame controller with an eraser/animator stand-in and compares
// every observable against a frame-level model of the sprite position.
// -----------------------------------------------------------------------------
module tb_pacman_frame_ctrl;

  localparam int FRAME_CYCLES = 8;
  localparam int TIMEOUT      = 16;
  localparam int INIT_X       = 70;
  localparam int INIT_Y       = 50;
  localparam int LIM_X        = 160 - 20;
  localparam int LIM_Y        = 120 - 20;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       busy;
  logic       hit_wall;
  logic       timeout_err;

  pacman_frame_ctrl_if hs();

  pacman_frame_ctrl #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .INIT_X       (INIT_X),
    .INIT_Y       (INIT_Y),
    .X_MIN        (0),
    .X_MAX        (LIM_X),
    .Y_MIN        (0),
    .Y_MAX        (LIM_Y),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .hs          (hs),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .busy        (busy),
    .hit_wall    (hit_wall),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  // Frame-level model: where the sprite is, what was last drawn, sticky error.
  int m_pos_x, m_pos_y, m_drawn_x, m_drawn_y;
  int m_tout;
  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos_x   = INIT_X;
    m_pos_y   = INIT_Y;
    m_drawn_x = INIT_X;
    m_drawn_y = INIT_Y;
    m_tout    = 0;
  endtask

  task automatic clear_dones();
    hs.erase_done = 1'b0;
    hs.anim_done  = 1'b0;
  endtask

  // Waits for erase_go, expecting it on the expect_n-th falling edge. While
  // the frame timer runs, stray done pulses are thrown at the controller.
  task automatic wait_erase_go(input int expect_n);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < expect_n + 6) begin
      @(negedge clock);
      n++;
      clear_dones();
      if (hs.erase_go) begin
        seen = 1'b1;
      end else begin
        check("idle_busy", busy, 1'b0);
        check("idle_anim_go", hs.anim_go, 1'b0);
        case ($urandom_range(0, 3))
          0: begin
            hs.anim_done  = 1'b1;
            hs.anim_out_x = 8'($urandom);
            hs.anim_out_y = 7'($urandom);
          end
          1: hs.erase_done = 1'b1;
          default: ;
        endcase
      end
    end
    check("frame_period", n, expect_n);
  endtask

  // One complete erase + animate handshake, starting in the erase_go cycle.
  task automatic run_frame(input int ed, input int ad, input logic [7:0] ox,
                           input logic [6:0] oy, input bit drop_enable);
    int exp_hit;
    check("erase_x", hs.erase_x, m_drawn_x);
    check("erase_y", hs.erase_y, m_drawn_y);
    check("busy_on_go", busy, 1'b1);
    if (drop_enable) enable = 1'b0;
    for (int k = 1; k <= ed; k++) begin
      @(negedge clock);
      clear_dones();
      check("erase_go_pulse", hs.erase_go, 1'b0);
      check("erase_wait_busy", busy, 1'b1);
      check("erase_wait_anim_go", hs.anim_go, 1'b0);
      if (k == ed) begin
        hs.erase_done = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          hs.anim_done  = 1'b1;
          hs.anim_out_x = 8'($urandom);
          hs.anim_out_y = 7'($urandom);
        end
      end
    end
    @(negedge clock);
    clear_dones();
    check("anim_go", hs.anim_go, 1'b1);
    check("anim_in_x", hs.anim_in_x, m_pos_x);
    check("anim_in_y", hs.anim_in_y, m_pos_y);
    for (int k = 1; k <= ad; k++) begin
      @(negedge clock);
      clear_dones();
      check("anim_go_pulse", hs.anim_go, 1'b0);
      check("anim_wait_erase_go", hs.erase_go, 1'b0);
      if (k == ad) begin
        hs.anim_done  = 1'b1;
        hs.anim_out_x = ox;
        hs.anim_out_y = oy;
        if ($urandom_range(0, 1) == 1) hs.erase_done = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        hs.erase_done = 1'b1;
      end
    end
    @(negedge clock);
    clear_dones();
    hs.anim_out_x = 8'($urandom);
    hs.anim_out_y = 7'($urandom);
    exp_hit = (int'(ox) <= LIM_X && int'(oy) <= LIM_Y) ? 0 : 1;
    check("hit_wall", hit_wall, exp_hit);
    check("update_busy", busy, 1'b1);
    m_drawn_x = int'(ox);
    m_drawn_y = int'(oy);
    if (exp_hit == 0) begin
      m_pos_x = int'(ox);
      m_pos_y = int'(oy);
    end
    @(negedge clock);
    check("hit_wall_pulse", hit_wall, 1'b0);
    check("done_busy", busy, 1'b0);
    check("pos_x", pos_x, m_pos_x);
    check("pos_y", pos_y, m_pos_y);
    check("timeout_err", timeout_err, m_tout);
    frame_no++;
    $display("frame %0d: out=(%0d,%0d) hit=%0d pos=(%0d,%0d) drawn=(%0d,%0d)",
             frame_no, ox, oy, exp_hit, pos_x, pos_y, m_drawn_x, m_drawn_y);
  endtask

  task automatic run_timeout();
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clock);
      check("wd_busy", busy, 1'b1);
      check("wd_err_early", timeout_err, 1'b0);
      check("wd_no_rego", hs.erase_go, 1'b0);
    end
    @(negedge clock);
    m_tout = 1;
    check("wd_err", timeout_err, 1'b1);
    check("wd_idle_busy", busy, 1'b0);
    check("wd_pos_x", pos_x, m_pos_x);
    check("wd_pos_y", pos_y, m_pos_y);
    $display("timeout: err=%0d busy=%0d pos=(%0d,%0d)", timeout_err, busy, pos_x, pos_y);
  endtask

  task automatic rand_frame();
    logic [7:0] ox;
    logic [6:0] oy;
    case ($urandom_range(0, 3))
      1: begin
        ox = 8'(LIM_X - 1 + int'($urandom_range(0, 2)));
        oy = 7'(LIM_Y - 1 + int'($urandom_range(0, 2)));
      end
      2: begin
        ox = 8'($urandom);
        oy = 7'($urandom);
      end
      default: begin
        ox = 8'(m_pos_x) + 8'($urandom_range(0, 6)) - 8'd3;
        oy = 7'(m_pos_y) + 7'($urandom_range(0, 6)) - 7'd3;
      end
    endcase
    run_frame(int'($urandom_range(2, 7)), int'($urandom_range(2, 7)), ox, oy, 1'b0);
  endtask

  initial begin
    clear_dones();
    hs.anim_out_x = '0;
    hs.anim_out_y = '0;
    model_reset();

    // Reset state.
    #12;
    check("rst_pos_x", pos_x, INIT_X);
    check("rst_pos_y", pos_y, INIT_Y);
    check("rst_erase_x", hs.erase_x, INIT_X);
    check("rst_erase_y", hs.erase_y, INIT_Y);
    check("rst_anim_in_x", hs.anim_in_x, INIT_X);
    check("rst_anim_in_y", hs.anim_in_y, INIT_Y);
    check("rst_busy", busy, 1'b0);
    check("rst_erase_go", hs.erase_go, 1'b0);
    check("rst_anim_go", hs.anim_go, 1'b0);
    check("rst_hit_wall", hit_wall, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("disabled_no_go", hs.erase_go, 1'b0);
      check("disabled_busy", busy, 1'b0);
    end
    enable = 1'b1;

    // Directed frames: first move, walk to x=5, underflow wrap, bound edges.
    wait_erase_go(FRAME_CYCLES + 1);
    run_frame(5, 3, 8'd77, 7'd50, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(4, 2, 8'd5, 7'd50, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(2, 2, 8'd254, 7'd50, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(3, 4, 8'd140, 7'd100, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(2, 3, 8'd141, 7'd100, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(2, 2, 8'd140, 7'd101, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(6, 2, 8'd0, 7'd0, 1'b0);
    wait_erase_go(FRAME_CYCLES);
    run_frame(2, 6, 8'd255, 7'd127, 1'b0);

    // Erase done withheld: watchdog abort, then normal frames resume.
    wait_erase_go(FRAME_CYCLES);
    run_timeout();
    wait_erase_go(FRAME_CYCLES + 1);
    run_frame(3, 3, 8'd60, 7'd40, 1'b0);

    // Enable dropped mid-handshake: frame completes, then the controller idles.
    wait_erase_go(FRAME_CYCLES);
    run_frame(3, 2, 8'd61, 7'd41, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("off_no_go", hs.erase_go, 1'b0);
      check("off_busy", busy, 1'b0);
    end
    enable = 1'b1;
    wait_erase_go(FRAME_CYCLES + 1);
    run_frame(2, 2, 8'd62, 7'd42, 1'b0);

    for (int f = 0; f < 30; f++) begin
      wait_erase_go(FRAME_CYCLES);
      rand_frame();
    end

    // Reset asserted while waiting for anim_done.
    wait_erase_go(FRAME_CYCLES);
    @(negedge clock);
    @(negedge clock);
    hs.erase_done = 1'b1;
    @(negedge clock);
    clear_dones();
    check("pre_rst_anim_go", hs.anim_go, 1'b1);
    @(negedge clock);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("arst_anim_go", hs.anim_go, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_pos_x", pos_x, m_pos_x);
    check("arst_pos_y", pos_y, m_pos_y);
    check("arst_erase_x", hs.erase_x, m_drawn_x);
    check("arst_timeout_err", timeout_err, 1'b0);
    $display("async reset: busy=%0d anim_go=%0d pos=(%0d,%0d)", busy, hs.anim_go, pos_x, pos_y);
    @(negedge clock);
    resetn = 1'b1;
    wait_erase_go(FRAME_CYCLES + 1);
    run_frame(2, 2, 8'd71, 7'd51, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
